instr_encoder: RTL
==================

# instr_encoder

Assembles RV32I instruction words from field-level requests: the inverse of the decode-stage control unit. It accepts one request per cycle over a valid/ready handshake, packs opcode, funct, register and immediate fields into a 32-bit word, and emits it with an auto-incrementing word address toward the instruction-memory loader. It is used by the host/quantum sequencer path to generate programs on-chip.

## Interface
- ADDR_W, 10: width of output word address.
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; IDLE->RUN, loads address counter.
- start_addr  in  ADDR_W  first word address.
- stop  in  1  pulse; RUN->IDLE once output register empty.
- clear  in  1  pulse; ERR->IDLE.
- req_valid / req_ready  in / out  1  request handshake.
- req_op  in  4  0 OP, 1 OP_IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC; 9-15 illegal.
- req_sub  in  4  [2:0] funct3; [3] alt bit (SUB/SRA -> funct7=0100000); ignored for JAL/JALR/LUI/AUIPC (JALR funct3=000).
- req_rd, req_rs1, req_rs2  in  5 each  register indices.
- req_imm  in  32  signed byte offset/immediate; LUI/AUIPC: full 32-bit value, low 12 bits discarded.
- out_valid / out_ready  out / in  1  output handshake.
- out_instr  out  32  encoded word.
- out_addr  out  ADDR_W  word address of out_instr.
- busy  out  1  state != IDLE or out_valid.
- err  out  1  high in ERR.
- err_op  out  4  req_op of offending request.

## Operation
- States IDLE, RUN, ERR; reset -> IDLE.
- IDLE: req_ready=0; start -> RUN, addr_cnt<=start_addr.
- RUN: req_ready = !out_valid || out_ready. Accepted request encoded combinationally, registered into output register with out_addr=addr_cnt; addr_cnt+1 (wraps mod 2^ADDR_W).
- stop in RUN: req_ready=0 from next cycle; -> IDLE when out_valid=0 (or drains that cycle). start in RUN ignored.
- Encoding: standard RV32I formats. OP: R-type. OP_IMM: I-type; funct3 001/101 use shamt=req_imm[4:0], imm[11:5]={0,alt,00000}. LOAD/JALR: I-type. STORE: S-type. BRANCH: B-type, imm[12:1]. JAL: J-type, imm[20:1]. LUI/AUIPC: U-type, req_imm[31:12].
- Fields not used by a format (e.g. rs2 for I-type) ignored.
- Illegal req_op (9-15): always -> ERR, not emitted (independent of macro).
- ERR: req_ready=0; pending output still drains; err=1, err_op held; clear -> IDLE. start ignored in ERR.
- Simultaneous stop and accepted request: request accepted and emitted, then stop honored. clear and start same cycle in ERR: clear wins, start ignored.

## Timing
- Latency: request accepted cycle N -> out_valid cycle N+1.
- Throughput 1 word/cycle with out_ready=1; output register holds stable (instr, addr) while out_valid && !out_ready.
- Error detected at acceptance; ERR entered cycle N+1; no word for that request.
- Reset values: req_ready=0, out_valid=0, out_instr=0, out_addr=0, busy=0, err=0, err_op=0, addr_cnt=0, state IDLE. rst mid-operation discards output register.

## Configuration
- ENCODER_RANGE_CHECK_EN defined: immediate range errors -> ERR. I/S: -2048..2047; shifts: 0..31; B: -4096..4094 and even; J: -1048576..1048574 and even; U: req_imm[11:0]==0.
- Undefined: no range check; immediates silently truncated to field width (low bit of B/J dropped); only illegal req_op reaches ERR.

## Test plan
- start(start_addr=0x010), ADDI x1,x0,5 (op1,sub0) -> cycle+1 out_instr=0x00500093, out_addr=0x010.
- Back-to-back ADD x3,x1,x2 then SUB (sub=4'b1000) -> 0x002081B3 @0x011, 0x402081B3 @0x012.
- BEQ x1,x2,+8 -> 0x00208463; JAL x1,+16 -> 0x010000EF; LUI x5,0x12345000 -> 0x123452B7.
- out_ready=0 for 3 cycles with word pending -> req_ready=0, out_instr/out_addr stable; release -> next word follows, no loss or duplication.
- With ENCODER_RANGE_CHECK_EN: ADDI imm=2048 -> no output, err=1, err_op=1, req_ready=0; clear -> IDLE, err=0. Without macro: same request -> 0x80000093 emitted.
- req_op=12 -> ERR, err_op=12; start_addr=0x3FF with two requests -> addresses 0x3FF then 0x000; rst mid-stream -> all outputs zero next cycle.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction assembler: packs field-level requests into 32-bit words with auto-incrementing addresses.
// Optional ENCODER_RANGE_CHECK_EN: out-of-range immediates send the block to ERR instead of truncating.
module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              stop,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [3:0]        req_sub,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              err,
    output logic [3:0]        err_op,
    output logic [1:0]        dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_ERR = 2'd2} state_t;

    state_t            r_state;
    logic              r_stopping;
    logic              r_out_valid;
    logic [31:0]       r_out_instr;
    logic [ADDR_W-1:0] r_out_addr;
    logic [ADDR_W-1:0] r_addr_cnt;
    logic [3:0]        r_err_op;

    logic [31:0] w_instr;
    logic        w_illegal;
    logic        w_range_err;
    logic        w_bad;
    logic        w_accept;
    logic        w_out_fire;
    logic        w_shift;
    logic [2:0]  w_f3;
    logic        w_alt;

    assign w_f3       = req_sub[2:0];
    assign w_alt      = req_sub[3];
    assign w_shift    = (w_f3 == 3'b001) || (w_f3 == 3'b101);
    assign req_ready  = (r_state == S_RUN) && !r_stopping && (!r_out_valid || out_ready);
    assign w_accept   = req_valid && req_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_bad      = w_illegal || w_range_err;

    always_comb begin
        w_instr   = 32'd0;
        w_illegal = 1'b0;
        case (req_op)
            4'd0: w_instr = {1'b0, w_alt, 5'b0, req_rs2, req_rs1, w_f3, req_rd, 7'b0110011};
            4'd1: begin
                if (w_shift)
                    w_instr = {1'b0, w_alt, 5'b0, req_imm[4:0], req_rs1, w_f3, req_rd, 7'b0010011};
                else
                    w_instr = {req_imm[11:0], req_rs1, w_f3, req_rd, 7'b0010011};
            end
            4'd2: w_instr = {req_imm[11:0], req_rs1, w_f3, req_rd, 7'b0000011};
            4'd3: w_instr = {req_imm[11:5], req_rs2, req_rs1, w_f3, req_imm[4:0], 7'b0100011};
            4'd4: w_instr = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, w_f3,
                             req_imm[4:1], req_imm[11], 7'b1100011};
            4'd5: w_instr = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                             req_rd, 7'b1101111};
            4'd6: w_instr = {req_imm[11:0], req_rs1, 3'b000, req_rd, 7'b1100111};
            4'd7: w_instr = {req_imm[31:12], req_rd, 7'b0110111};
            4'd8: w_instr = {req_imm[31:12], req_rd, 7'b0010111};
            default: w_illegal = 1'b1;
        endcase
    end

`ifdef ENCODER_RANGE_CHECK_EN
    logic w_fit_i;
    logic w_fit_b;
    logic w_fit_j;

    // An immediate fits a signed field when all bits above it are copies of its sign bit.
    assign w_fit_i = (&req_imm[31:11]) || !(|req_imm[31:11]);
    assign w_fit_b = (&req_imm[31:12]) || !(|req_imm[31:12]);
    assign w_fit_j = (&req_imm[31:20]) || !(|req_imm[31:20]);

    always_comb begin
        w_range_err = 1'b0;
        case (req_op)
            4'd1:             w_range_err = w_shift ? (req_imm[31:5] != 27'd0) : !w_fit_i;
            4'd2, 4'd3, 4'd6: w_range_err = !w_fit_i;
            4'd4:             w_range_err = !w_fit_b || req_imm[0];
            4'd5:             w_range_err = !w_fit_j || req_imm[0];
            4'd7, 4'd8:       w_range_err = (req_imm[11:0] != 12'd0);
            default:          w_range_err = 1'b0;
        endcase
    end
`else
    assign w_range_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_stopping  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_instr <= 32'd0;
            r_out_addr  <= '0;
            r_addr_cnt  <= '0;
            r_err_op    <= 4'd0;
        end else begin
            // The output register drains in every state so a pending word survives stop/ERR.
            if (w_out_fire)
                r_out_valid <= 1'b0;
            if (w_accept && !w_bad) begin
                r_out_valid <= 1'b1;
                r_out_instr <= w_instr;
                r_out_addr  <= r_addr_cnt;
                r_addr_cnt  <= r_addr_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_addr_cnt <= start_addr;
                        r_stopping <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_accept && w_bad) begin
                        r_state    <= S_ERR;
                        r_err_op   <= req_op;
                        r_stopping <= 1'b0;
                    end else if (stop || r_stopping) begin
                        if (!w_accept && (!r_out_valid || out_ready)) begin
                            r_state    <= S_IDLE;
                            r_stopping <= 1'b0;
                        end else begin
                            r_stopping <= 1'b1;
                        end
                    end
                end
                S_ERR: begin
                    if (clear)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_addr  = r_out_addr;
    assign busy      = (r_state != S_IDLE) || r_out_valid;
    assign err       = (r_state == S_ERR);
    assign err_op    = r_err_op;
    assign dbg_state = r_state;

endmodule
